// File: rtl/sample_hold_bank.sv
// Capture bank for a WIDTH-bit input. It keeps a DEPTH-entry shift history and tracks
// occupancy and a wrapping sample counter. Define CHANGE_ONLY_EN to drop repeated samples.
module sample_hold_bank #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8,
   localparam int SEL_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             sample_en,
   input  logic [1:0]       mode,
   input  logic             clr,
   input  logic [SEL_W-1:0] rd_sel,
   output logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] hist_out,
   output logic             valid,
   output logic             full,
   output logic [SEL_W:0]   fill_cnt,
   output logic [CNT_W-1:0] sample_cnt
);

   localparam logic [1:0] MODE_TRANS = 2'b00;
   localparam logic [1:0] MODE_LEVEL = 2'b01;
   localparam logic [1:0] MODE_EDGE  = 2'b10;
   localparam logic [SEL_W:0] DEPTH_L = (SEL_W+1)'(DEPTH);

   logic [WIDTH-1:0] hist [DEPTH];
   logic             en_q;
   logic             cap_raw;
   logic             cap;

   always_comb begin
      cap_raw = 1'b0;
      case (mode)
         MODE_TRANS: cap_raw = 1'b1;
         MODE_LEVEL: cap_raw = sample_en;
         MODE_EDGE:  cap_raw = sample_en & ~en_q;
         default:    cap_raw = 1'b0;
      endcase
   end

`ifdef CHANGE_ONLY_EN
   // A repeat of the newest stored value is ignored; an empty bank always accepts.
   assign cap = cap_raw & ~(valid & (din == hist[0]));
`else
   assign cap = cap_raw;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
         en_q       <= 1'b0;
         valid      <= 1'b0;
         fill_cnt   <= '0;
         sample_cnt <= '0;
      end else begin
         en_q <= sample_en;
         // clr wins over a capture in the same cycle.
         if (clr) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
            valid      <= 1'b0;
            fill_cnt   <= '0;
            sample_cnt <= '0;
         end else if (cap) begin
            hist[0] <= din;
            for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
            valid      <= 1'b1;
            sample_cnt <= sample_cnt + CNT_W'(1);
            if (fill_cnt != DEPTH_L) fill_cnt <= fill_cnt + 1'b1;
         end
      end
   end

   assign dout = hist[0];
   assign full = (fill_cnt == DEPTH_L);

   always_comb begin
      hist_out = '0;
      if (({1'b0, rd_sel} < fill_cnt) && (int'(rd_sel) < DEPTH)) hist_out = hist[rd_sel];
   end

endmodule
